// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with clock glitch filter, frame
// timeout, parity/frame error pulses and a first-word fall-through FIFO.
// Optional build macro PS2_RX_PREFIX_DECODE_EN folds E0/F0 prefix bytes into
// ext/brk flags stored alongside the following scan code.
module ps2_rx_fifo #(
    parameter int ADDR_W   = 3,
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 5000,
    parameter int OVF_KEEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              nextdata_n,
    input  logic              ovf_clr,
    output logic [7:0]        data,
    output logic              data_ext,
    output logic              data_brk,
    output logic              ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              parity_err,
    output logic              frame_err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int FCW   = $clog2(FILT_LEN + 1);
    localparam int TCW   = $clog2(TIMEOUT + 1);
`ifdef PS2_RX_PREFIX_DECODE_EN
    localparam int W = 10;
`else
    localparam int W = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

    // ---------------- input conditioning ----------------
    logic [1:0]     clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic           filt_q, filt_d, strb_q, strb_d, bit_q, bit_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    // Synchronise the pins and only let the clock change after FILT_LEN agreeing samples.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_data};
        filt_d     = filt_q;
        fcnt_d     = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FCW'(FILT_LEN - 1))
                filt_d = clk_sync_q[1];
            else
                fcnt_d = fcnt_q + 1'b1;
        end
        strb_d = filt_q & ~filt_d;
        bit_d  = dat_sync_q[1];
    end

    // Front-end registers; the pins idle high so everything resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            strb_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            strb_q     <= strb_d;
            bit_q      <= bit_d;
        end
    end

    // ---------------- frame FSM ----------------
    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d, push_q, push_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic [W-1:0]   push_data_q, push_data_d;
`ifdef PS2_RX_PREFIX_DECODE_EN
    logic           ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
`endif

    // Next-state logic: bit collection, stop/parity verdict, timeout abort and prefix folding.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
`ifdef PS2_RX_PREFIX_DECODE_EN
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
`endif
        tmo_d = (state_q == S_IDLE || strb_q) ? '0 : tmo_q + 1'b1;
        case (state_q)
            S_IDLE: if (strb_q && !bit_q) begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: if (strb_q) begin
                shift_d = {bit_q, shift_q[7:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == 3'd7) state_d = S_PAR;
            end
            S_PAR: if (strb_q) begin
                par_d   = bit_q;
                state_d = S_STOP;
            end
            default: if (strb_q) begin
                state_d = S_IDLE;
                if (!bit_q)
                    ferr_d = 1'b1;
                else if (!(^{shift_q, par_q}))
                    perr_d = 1'b1;
                else begin
`ifdef PS2_RX_PREFIX_DECODE_EN
                    if (shift_q == 8'hE0)
                        ext_pend_d = 1'b1;
                    else if (shift_q == 8'hF0)
                        brk_pend_d = 1'b1;
                    else begin
                        push_d      = 1'b1;
                        push_data_d = {ext_pend_q, brk_pend_q, shift_q};
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end
`else
                    push_d      = 1'b1;
                    push_data_d = shift_q;
`endif
                end
            end
        endcase
        // A stalled frame is abandoned once the strobe has been absent for TIMEOUT cycles.
        if (state_q != S_IDLE && !strb_q && tmo_q == TCW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
        end
`ifdef PS2_RX_PREFIX_DECODE_EN
        if (perr_d || ferr_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
`ifdef PS2_RX_PREFIX_DECODE_EN
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
`ifdef PS2_RX_PREFIX_DECODE_EN
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
`endif
        end
    end

    // ---------------- FIFO ----------------
    logic [W-1:0]      mem [DEPTH];
    logic [W-1:0]      head_q, head_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              do_pop, full, ovf_evt, do_wr, rd_adv;

    // Pointer/level bookkeeping; the head is prefetched from the next read pointer
    // with a bypass so a write into the about-to-be-head slot is visible at once.
    always_comb begin
        do_pop  = (level_q != '0) && !nextdata_n;
        full    = (level_q == (ADDR_W + 1)'(DEPTH));
        ovf_evt = push_q && full && !do_pop;
        do_wr   = push_q && (!ovf_evt || OVF_KEEP == 0);
        rd_adv  = do_pop || (ovf_evt && OVF_KEEP == 0);
        rptr_d  = rd_adv ? rptr_q + 1'b1 : rptr_q;
        wptr_d  = do_wr ? wptr_q + 1'b1 : wptr_q;
        level_d = level_q;
        if (do_wr && !rd_adv)
            level_d = level_q + 1'b1;
        else if (rd_adv && !do_wr)
            level_d = level_q - 1'b1;
        ovf_d   = ovf_evt ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        head_d  = (do_wr && wptr_q == rptr_d) ? push_data_q : mem[rptr_d];
    end

    // Storage array and registered head read; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr_q] <= push_data_q;
        head_q <= head_d;
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data       = head_q[7:0];
`ifdef PS2_RX_PREFIX_DECODE_EN
    assign data_ext   = head_q[9];
    assign data_brk   = head_q[8];
`else
    assign data_ext   = 1'b0;
    assign data_brk   = 1'b0;
`endif
    assign ready      = (level_q != '0);
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: drives two receivers (OVF_KEEP=1 and OVF_KEEP=0) with the same
// PS/2 frames; a queue model of the stored scan codes is compared every idle cycle.
module tb_ps2_rx_fifo;
    localparam int ADDR_W = 3, DEPTH = 8, FILT_LEN = 4, TIMEOUT = 200, HALF = 20;

    logic clk = 1'b0;
    logic rst, ps2_clk, ps2_data, nextdata_n, ovf_clr;
    logic [7:0] data_a, data_b;
    logic ext_a, ext_b, brk_a, brk_b, ready_a, ready_b, ovf_a, ovf_b, pe_a, pe_b, fe_a, fe_b;
    logic [ADDR_W:0] level_a, level_b;

    ps2_rx_fifo #(.ADDR_W(ADDR_W), .FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT), .OVF_KEEP(1)) u_keep (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
        .ovf_clr(ovf_clr), .data(data_a), .data_ext(ext_a), .data_brk(brk_a), .ready(ready_a),
        .level(level_a), .overflow(ovf_a), .parity_err(pe_a), .frame_err(fe_a));

    ps2_rx_fifo #(.ADDR_W(ADDR_W), .FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT), .OVF_KEEP(0)) u_over (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
        .ovf_clr(ovf_clr), .data(data_b), .data_ext(ext_b), .data_brk(brk_b), .ready(ready_b),
        .level(level_b), .overflow(ovf_b), .parity_err(pe_b), .frame_err(fe_b));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int lat = 8;
    int exp_pe = 0, exp_fe = 0;
    int pe_cnt [2];
    int fe_cnt [2];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    bit ovf_m [2];
    bit ext_p = 0, brk_p = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string t, input int n, input logic [9:0] hd, input bit om,
                       input logic r, input logic [ADDR_W:0] lv, input logic o,
                       input logic [7:0] d, input logic e, input logic b);
        check({t, "_ready"}, 32'(r), 32'(n != 0));
        check({t, "_level"}, 32'(lv), 32'(n));
        check({t, "_overflow"}, 32'(o), 32'(om));
        if (n != 0) begin
            check({t, "_data"}, 32'(d), 32'(hd[7:0]));
            check({t, "_ext"}, 32'(e), 32'(hd[9]));
            check({t, "_brk"}, 32'(b), 32'(hd[8]));
        end
    endtask

    // Error pulse counters (counting high cycles exposes stretched pulses).
    always @(negedge clk) begin
        if (rst) begin
            pe_cnt[0] = 0; pe_cnt[1] = 0; fe_cnt[0] = 0; fe_cnt[1] = 0;
        end else begin
            pe_cnt[0] += int'(pe_a); pe_cnt[1] += int'(pe_b);
            fe_cnt[0] += int'(fe_a); fe_cnt[1] += int'(fe_b);
        end
    end

    // Per-cycle comparison against the queue model while the bus is quiet.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("keep", q0.size(), (q0.size() != 0) ? q0[0] : 10'h0, ovf_m[0],
                ready_a, level_a, ovf_a, data_a, ext_a, brk_a);
            cmp("over", q1.size(), (q1.size() != 0) ? q1[0] : 10'h0, ovf_m[1],
                ready_b, level_b, ovf_b, data_b, ext_b, brk_b);
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Model of an accepted byte arriving at both FIFOs.
    task automatic push_model(input logic [7:0] b);
        logic [9:0] e;
        bit do_push;
        do_push = 1;
        e = {2'b00, b};
`ifdef PS2_RX_PREFIX_DECODE_EN
        if (b == 8'hE0) begin ext_p = 1; do_push = 0; end
        else if (b == 8'hF0) begin brk_p = 1; do_push = 0; end
        else begin e = {ext_p, brk_p, b}; ext_p = 0; brk_p = 0; end
`endif
        if (do_push) begin
            if (q0.size() == DEPTH) ovf_m[0] = 1; else q0.push_back(e);
            if (q1.size() == DEPTH) begin ovf_m[1] = 1; void'(q1.pop_front()); end
            q1.push_back(e);
        end
    endtask

    task automatic err_model();
        ext_p = 0; brk_p = 0;
    endtask

    task automatic pop_model();
        if (q0.size() != 0) void'(q0.pop_front());
        if (q1.size() != 0) void'(q1.pop_front());
    endtask

    task automatic pop_one();
        chk_en = 0;
        nextdata_n = 0;
        cyc_wait(1);
        nextdata_n = 1;
        pop_model();
        chk_en = 1;
        cyc_wait(1);
    endtask

    // Sends nbits of a frame (start, 8 data LSB first, odd parity, stop).
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch, input bit popstop, input bit calib);
        logic [10:0] f;
        logic [ADDR_W:0] lv0;
        bit found;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        chk_en = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (glitch && i == 4) begin
                cyc_wait(8); ps2_clk = 0; cyc_wait(2); ps2_clk = 1; cyc_wait(HALF - 10);
            end else
                cyc_wait(HALF);
            ps2_clk = 0;
            if (i == 10 && popstop) begin
                cyc_wait(lat - 1); nextdata_n = 0; cyc_wait(1); nextdata_n = 1; cyc_wait(HALF - lat);
            end else if (i == 10 && calib) begin
                lv0 = level_a;
                found = 0;
                for (int k = 0; k < HALF; k++) begin
                    cyc_wait(1);
                    if (!found && level_a != lv0) begin found = 1; lat = k + 1; end
                end
                if (!found) begin
                    total++; bad++;
                    $display("FAIL push_latency got=none want=push within %0d cycles", HALF);
                end
            end else
                cyc_wait(HALF);
            ps2_clk = 1;
        end
        ps2_data = 1;
        cyc_wait(HALF);
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, 0, 0, 11, 0, 0, 0);
        push_model(b);
        chk_en = 1;
        cyc_wait(2);
    endtask

    task automatic check_errs(input string t);
        check({t, "_pe_keep"}, pe_cnt[0], exp_pe);
        check({t, "_pe_over"}, pe_cnt[1], exp_pe);
        check({t, "_fe_keep"}, fe_cnt[0], exp_fe);
        check({t, "_fe_over"}, fe_cnt[1], exp_fe);
    endtask

    initial begin
        rst = 1; ps2_clk = 1; ps2_data = 1; nextdata_n = 1; ovf_clr = 0;
        cyc_wait(5);
        rst = 0;
        cyc_wait(2);
        check("rst_ready", ready_a, 0);
        check("rst_level", level_a, 0);
        check("rst_overflow", ovf_a, 0);
        check("rst_level_over", level_b, 0);
        check("rst_perr", pe_a, 0);
        check("rst_ferr", fe_a, 0);
        chk_en = 1;
        cyc_wait(2);

        // 1: single good frame, then pop
        send_frame(8'h1C, 0, 0, 11, 0, 0, 1);
        push_model(8'h1C);
        check("t1_level", level_a, 1);
        check("t1_ready", ready_a, 1);
        check("t1_data", data_a, 8'h1C);
        chk_en = 1;
        cyc_wait(2);
        pop_one();
        check("t1_pop_ready", ready_a, 0);
        check("t1_pop_level", level_a, 0);

        // 2: parity error, then stop-bit error
        send_frame(8'h1C, 1, 0, 11, 0, 0, 0);
        err_model(); exp_pe++;
        chk_en = 1; cyc_wait(2);
        check_errs("t2_par");
        send_frame(8'h33, 0, 1, 11, 0, 0, 0);
        err_model(); exp_fe++;
        chk_en = 1; cyc_wait(2);
        check_errs("t2_stop");
        check("t2_level", level_a, 0);

        // 3: nine frames into an 8-deep FIFO
        for (int v = 1; v <= 9; v++) good_frame(8'(v));
        check("t3_keep_level", level_a, 8);
        check("t3_over_level", level_b, 8);
        check("t3_keep_ovf", ovf_a, 1);
        check("t3_over_ovf", ovf_b, 1);
        check("t3_keep_head", data_a, 8'h01);
        check("t3_over_head", data_b, 8'h02);
        chk_en = 0;
        ovf_clr = 1; cyc_wait(1); ovf_clr = 0;
        ovf_m[0] = 0; ovf_m[1] = 0;
        chk_en = 1; cyc_wait(1);
        check("t3_ovf_clr", ovf_a, 0);
        repeat (8) pop_one();

        // 5b: push coinciding with pop while full
        for (int v = 8'h11; v <= 8'h18; v++) good_frame(8'(v));
        send_frame(8'h19, 0, 0, 11, 0, 1, 0);
        pop_model();
        push_model(8'h19);
        check("t5_level", level_a, 8);
        check("t5_ovf_keep", ovf_a, 0);
        check("t5_ovf_over", ovf_b, 0);
        check("t5_head", data_a, 8'h12);
        chk_en = 1; cyc_wait(2);
        repeat (8) pop_one();

        // 4: partial frame, timeout, then recovery
        send_frame(8'hFF, 0, 0, 5, 0, 0, 0);
        cyc_wait(TIMEOUT + 20);
        err_model(); exp_fe++;
        chk_en = 1; cyc_wait(2);
        check_errs("t4_timeout");
        good_frame(8'h2A);
        check("t4_data", data_a, 8'h2A);
        pop_one();

        // 5a: glitch on ps2_clk mid-frame
        send_frame(8'h5A, 0, 0, 11, 1, 0, 0);
        push_model(8'h5A);
        check("t5_glitch_data", data_a, 8'h5A);
        check("t5_glitch_level", level_a, 1);
        chk_en = 1; cyc_wait(2);
        pop_one();

        // 6: prefix sequence
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h75);
`ifdef PS2_RX_PREFIX_DECODE_EN
        check("t6_level", level_a, 1);
        check("t6_data", data_a, 8'h75);
        check("t6_ext", ext_a, 1);
        check("t6_brk", brk_a, 1);
        pop_one();
`else
        check("t6_level", level_a, 3);
        check("t6_data", data_a, 8'hE0);
        check("t6_ext", ext_a, 0);
        repeat (3) pop_one();
`endif
        good_frame(8'h75);
        check("t6_plain_data", data_a, 8'h75);
        check("t6_plain_ext", ext_a, 0);
        check("t6_plain_brk", brk_a, 0);
        pop_one();

        check_errs("final");
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
